// File: rtl/pipeline_skid_reg.sv
// pipeline_skid_reg: elastic valid/ready stage register with one-entry skid buffer and flush-to-NOP.
// Optional saturating stall/bubble counters are enabled by defining PREG_STATS_EN.
module pipeline_skid_reg #(
    parameter int               RSIZE   = 64,
    parameter logic [RSIZE-1:0] NOP_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RSIZE-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RSIZE-1:0] out_data
`ifdef PREG_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t           r_state;
    logic [RSIZE-1:0] r_main;
    logic [RSIZE-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_take;

    assign w_accept  = in_valid & r_in_ready;
    assign w_take    = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

    // Handshake outputs are registered alongside the state so in_ready never sees out_ready combinationally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= EMPTY;
            r_main      <= NOP_VAL;
            r_skid      <= NOP_VAL;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_main      <= NOP_VAL;
            r_skid      <= NOP_VAL;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main      <= in_data;
                        r_state     <= BUSY;
                        r_out_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_accept && w_take) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_skid     <= in_data;
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_take) begin
                        r_main      <= NOP_VAL;
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_take) begin
                        r_main     <= r_skid;
                        r_skid     <= NOP_VAL;
                        r_state    <= BUSY;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_main      <= NOP_VAL;
                    r_skid      <= NOP_VAL;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PREG_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_stall;
    logic             w_bubble;

    assign w_stall    = r_out_valid & ~out_ready & ~flush;
    assign w_bubble   = ~r_out_valid & out_ready;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

    // Counters saturate and survive flush; only nRST clears them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_stall_cnt  <= (w_stall && r_stall_cnt != '1) ? r_stall_cnt + 1'b1 : r_stall_cnt;
            r_bubble_cnt <= (w_bubble && r_bubble_cnt != '1) ? r_bubble_cnt + 1'b1 : r_bubble_cnt;
        end
    end
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_skid_reg.sv
// tb_pipeline_skid_reg: table-driven check of pipeline_skid_reg handshake, flush and async reset.
// Counter checks run only when PREG_STATS_EN is defined.
module tb_pipeline_skid_reg;
    localparam logic [63:0] NOP = 64'h0000_0020_0000_0000;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
`ifdef PREG_STATS_EN
    logic [3:0]  stall_cnt;
    logic [3:0]  bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipeline_skid_reg #(.RSIZE(64), .NOP_VAL(NOP), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PREG_STATS_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic [63:0] q;
    } vec_t;

    vec_t vecs[21];

    function automatic logic [63:0] bd(input int pc);
        return {32'hA000_0000 + 32'(pc), 32'(pc)};
    endfunction

    function automatic vec_t mk(input logic fl, iv, input int pc, input logic ordy, ov, ir, input int qpc);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = bd(pc); v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.q = (qpc == 0) ? NOP : bd(qpc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic fl, iv, input logic [63:0] d, input logic ordy);
        flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string nm, input logic ov, ir, input logic [63:0] q);
        chk({nm, " out_valid"}, 64'(out_valid), 64'(ov));
        chk({nm, " in_ready"}, 64'(in_ready), 64'(ir));
        chk({nm, " out_data"}, out_data, q);
    endtask

    initial begin
        //            fl  iv  pc  or  ov  ir  qpc
        vecs[0]  = mk(0,  1,  14, 1,  1,  1,  14);
        vecs[1]  = mk(0,  1,  16, 1,  1,  1,  16);
        vecs[2]  = mk(0,  1,  18, 1,  1,  1,  18);
        vecs[3]  = mk(0,  0,  0,  1,  0,  1,  0);
        vecs[4]  = mk(0,  1,  14, 0,  1,  1,  14);
        vecs[5]  = mk(0,  1,  16, 0,  1,  0,  14);
        vecs[6]  = mk(0,  0,  0,  0,  1,  0,  14);
        vecs[7]  = mk(0,  0,  0,  1,  1,  1,  16);
        vecs[8]  = mk(0,  0,  0,  1,  0,  1,  0);
        vecs[9]  = mk(0,  1,  20, 0,  1,  1,  20);
        vecs[10] = mk(0,  1,  22, 0,  1,  0,  20);
        vecs[11] = mk(1,  1,  26, 1,  0,  1,  0);
        vecs[12] = mk(0,  0,  0,  1,  0,  1,  0);
        vecs[13] = mk(0,  1,  30, 0,  1,  1,  30);
        vecs[14] = mk(1,  1,  32, 1,  0,  1,  0);
        vecs[15] = mk(0,  0,  0,  1,  0,  1,  0);
        vecs[16] = mk(0,  1,  40, 0,  1,  1,  40);
        vecs[17] = mk(0,  1,  42, 0,  1,  0,  40);
        vecs[18] = mk(0,  1,  44, 1,  1,  1,  42);
        vecs[19] = mk(0,  1,  44, 1,  1,  1,  44);
        vecs[20] = mk(0,  0,  0,  1,  0,  1,  0);

        repeat (2) @(posedge CLK);
        #1;
        chk_state("in_reset", 1'b0, 1'b1, NOP);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        chk_state("after_reset", 1'b0, 1'b1, NOP);

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            chk_state($sformatf("v%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].q);
        end

        step(0, 1, bd(60), 0);
        step(0, 1, bd(62), 0);
        chk_state("pre_async_full", 1'b1, 1'b0, bd(60));
        in_valid = 1'b0;
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk_state("async_reset", 1'b0, 1'b1, NOP);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        chk_state("async_release", 1'b0, 1'b1, NOP);
        step(0, 1, bd(64), 1);
        chk_state("post_reset_accept", 1'b1, 1'b1, bd(64));
        step(0, 0, bd(0), 1);
        chk_state("post_reset_drain", 1'b0, 1'b1, NOP);

`ifdef PREG_STATS_EN
        out_ready = 1'b0;
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("stall_rst", 64'(stall_cnt), 64'd0);
        chk("bubble_rst", 64'(bubble_cnt), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        step(0, 1, bd(50), 0);
        repeat (20) step(0, 0, bd(0), 0);
        chk("stall_sat", 64'(stall_cnt), 64'd15);
        chk("bubble_zero", 64'(bubble_cnt), 64'd0);
        step(1, 0, bd(0), 0);
        chk("stall_after_flush", 64'(stall_cnt), 64'd15);
        step(0, 0, bd(0), 1);
        chk("bubble_one", 64'(bubble_cnt), 64'd1);
        chk("stall_hold", 64'(stall_cnt), 64'd15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
